// File: rtl/pellet_map_ctrl.sv
// Pellet map controller: a 1024x1 single-port map shared between the renderer
// and game-logic eat requests, with a refill sweep and a pellet counter.
module pellet_map_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       level_start,
  input  logic       rd_en,
  input  logic [4:0] rd_x,
  input  logic [4:0] rd_y,
  output logic       rd_data,
  input  logic       eat_req,
  input  logic [4:0] eat_x,
  input  logic [4:0] eat_y,
  output logic       eat_ack,
  output logic       eat_hit,
  output logic       busy,
  output logic [9:0] pellets_left,
  output logic       level_clear
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_EAT_RD,
    ST_EAT_WR,
    ST_ACK
  } state_t;

  localparam logic [9:0] FULL_COUNT = 10'd900;
  localparam logic [9:0] LAST_ADDR  = 10'd1023;

  state_t     state_q, state_d;
  logic [9:0] sweep_addr_q, sweep_addr_d;
  logic [9:0] eat_addr_q, eat_addr_d;
  logic       hit_q, hit_d;
  logic       rd_data_q, rd_data_d;
  logic       eat_ack_q, eat_ack_d;
  logic       eat_hit_q, eat_hit_d;
  logic       busy_q, busy_d;
  logic [9:0] pellets_q, pellets_d;
  logic       level_clear_q, level_clear_d;

  logic       mem [0:1023];
  logic [9:0] mem_addr;
  logic       mem_we;
  logic       mem_wdata;
  logic       mem_rdata;
  logic [4:0] sweep_x;
  logic [4:0] sweep_y;
  logic       sweep_play;

  assign sweep_x    = sweep_addr_q[4:0];
  assign sweep_y    = sweep_addr_q[9:5];
  assign sweep_play = (sweep_x != 5'd0) && (sweep_x != 5'd31) &&
                      (sweep_y != 5'd0) && (sweep_y != 5'd31);

  // Single array port: refill sweep first, then renderer, then the eat sequence.
  always_comb begin
    mem_addr  = eat_addr_q;
    mem_we    = 1'b0;
    mem_wdata = 1'b0;
    if (state_q == ST_INIT) begin
      mem_addr  = sweep_addr_q;
      mem_we    = 1'b1;
      mem_wdata = sweep_play;
    end else if (rd_en) begin
      mem_addr = {rd_y, rd_x};
    end else if ((state_q == ST_EAT_WR) && !level_start) begin
      mem_we = 1'b1;
    end
  end

  assign mem_rdata = mem[mem_addr];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    eat_addr_d   = eat_addr_q;
    hit_d        = hit_q;
    pellets_d    = pellets_q;
    eat_ack_d    = 1'b0;
    eat_hit_d    = 1'b0;
    rd_data_d    = rd_data_q;

    if ((state_q != ST_INIT) && rd_en) begin
      rd_data_d = mem_rdata;
    end

    case (state_q)
      ST_INIT: begin
        if (sweep_addr_q == LAST_ADDR) begin
          state_d   = ST_IDLE;
          pellets_d = FULL_COUNT;
        end else begin
          sweep_addr_d = sweep_addr_q + 10'd1;
        end
      end
      ST_IDLE: begin
        if (eat_req) begin
          eat_addr_d = {eat_y, eat_x};
          state_d    = ST_EAT_RD;
        end
      end
      ST_EAT_RD: begin
        if (!rd_en) begin
          hit_d   = mem_rdata;
          state_d = ST_EAT_WR;
        end
      end
      ST_EAT_WR: begin
        if (!rd_en) begin
          state_d   = ST_ACK;
          eat_ack_d = 1'b1;
          eat_hit_d = hit_q;
          if (hit_q && (pellets_q != 10'd0)) begin
            pellets_d = pellets_q - 10'd1;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // A refill request wins over everything and drops any eat in flight.
    if (level_start) begin
      state_d      = ST_INIT;
      sweep_addr_d = 10'd0;
      pellets_d    = pellets_q;
      eat_ack_d    = 1'b0;
      eat_hit_d    = 1'b0;
    end

    if (state_d == ST_INIT) begin
      rd_data_d = 1'b0;
    end

    busy_d        = (state_d == ST_INIT);
    level_clear_d = (pellets_q == 10'd0) && (state_q != ST_INIT) &&
                    (state_d != ST_INIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_INIT;
      sweep_addr_q  <= 10'd0;
      eat_addr_q    <= 10'd0;
      hit_q         <= 1'b0;
      rd_data_q     <= 1'b0;
      eat_ack_q     <= 1'b0;
      eat_hit_q     <= 1'b0;
      busy_q        <= 1'b1;
      pellets_q     <= 10'd0;
      level_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_addr_q  <= sweep_addr_d;
      eat_addr_q    <= eat_addr_d;
      hit_q         <= hit_d;
      rd_data_q     <= rd_data_d;
      eat_ack_q     <= eat_ack_d;
      eat_hit_q     <= eat_hit_d;
      busy_q        <= busy_d;
      pellets_q     <= pellets_d;
      level_clear_q <= level_clear_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign eat_ack      = eat_ack_q;
  assign eat_hit      = eat_hit_q;
  assign busy         = busy_q;
  assign pellets_left = pellets_q;
  assign level_clear  = level_clear_q;

endmodule

// File: tb/tb_pellet_map_ctrl.sv
// Directed self-checking bench for pellet_map_ctrl: refill sweep, renderer
// reads, eat handshakes, render stalls, level restart and async reset.
module tb_pellet_map_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       level_start;
  logic       rd_en;
  logic [4:0] rd_x;
  logic [4:0] rd_y;
  logic       rd_data;
  logic       eat_req;
  logic [4:0] eat_x;
  logic [4:0] eat_y;
  logic       eat_ack;
  logic       eat_hit;
  logic       busy;
  logic [9:0] pellets_left;
  logic       level_clear;

  int checks = 0;
  int fails  = 0;

  pellet_map_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .level_start  (level_start),
    .rd_en        (rd_en),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_data      (rd_data),
    .eat_req      (eat_req),
    .eat_x        (eat_x),
    .eat_y        (eat_y),
    .eat_ack      (eat_ack),
    .eat_hit      (eat_hit),
    .busy         (busy),
    .pellets_left (pellets_left),
    .level_clear  (level_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [4:0] x, input logic [4:0] y, output logic v);
    rd_en = 1'b1;
    rd_x  = x;
    rd_y  = y;
    tick();
    v     = rd_data;
    rd_en = 1'b0;
  endtask

  // Returns in the cycle the ack is visible (or after the cycle budget).
  task automatic do_eat(input logic [4:0] x, input logic [4:0] y,
                        output logic acked, output logic hit, output int lat);
    eat_req = 1'b1;
    eat_x   = x;
    eat_y   = y;
    acked   = 1'b0;
    hit     = 1'b0;
    lat     = 0;
    for (int i = 1; (i <= 50) && !acked; i++) begin
      tick();
      if (eat_ack === 1'b1) begin
        acked = 1'b1;
        hit   = eat_hit;
        lat   = i;
      end
    end
    eat_req = 1'b0;
  endtask

  task automatic test_init_sweep(input string tag);
    int busy_low;
    int acks;
    busy_low = 0;
    acks     = 0;
    for (int i = 0; i < 1023; i++) begin
      tick();
      if (busy !== 1'b1) busy_low++;
      if (eat_ack !== 1'b0) acks++;
    end
    checks++;
    if (busy_low != 0) begin
      fails++;
      $display("[TB] FAIL %s busy_during_sweep: low for %0d cycles, required 0", tag, busy_low);
    end
    checks++;
    if (acks != 0) begin
      fails++;
      $display("[TB] FAIL %s ack_during_sweep: %0d acks, required 0", tag, acks);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s busy_after_sweep: got %b, required 0", tag, busy);
    end
    checks++;
    if (pellets_left !== 10'd900) begin
      fails++;
      $display("[TB] FAIL %s pellets_after_sweep: got %0d, required 900", tag, pellets_left);
    end
    tick();
    checks++;
    if (level_clear !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s level_clear_after_sweep: got %b, required 0", tag, level_clear);
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    level_start = 1'b0;
    rd_en       = 1'b0;
    rd_x        = 5'd0;
    rd_y        = 5'd0;
    eat_req     = 1'b0;
    eat_x       = 5'd0;
    eat_y       = 5'd0;
    repeat (3) tick();
    checks++;
    if ({busy, rd_data, eat_ack, eat_hit, level_clear} !== 5'b10000) begin
      fails++;
      $display("[TB] FAIL reset_flags: got busy/rd/ack/hit/clr=%b, required 10000",
               {busy, rd_data, eat_ack, eat_hit, level_clear});
    end
    checks++;
    if (pellets_left !== 10'd0) begin
      fails++;
      $display("[TB] FAIL reset_pellets: got %0d, required 0", pellets_left);
    end
    reset_n = 1'b1;
    test_init_sweep("reset");
  endtask

  task automatic test_reads();
    logic v;
    do_read(5'd0, 5'd5, v);
    checks++;
    if (v !== 1'b0) begin fails++; $display("[TB] FAIL read_0_5: got %b, required 0", v); end
    do_read(5'd31, 5'd31, v);
    checks++;
    if (v !== 1'b0) begin fails++; $display("[TB] FAIL read_31_31: got %b, required 0", v); end
    do_read(5'd1, 5'd1, v);
    checks++;
    if (v !== 1'b1) begin fails++; $display("[TB] FAIL read_1_1: got %b, required 1", v); end
    do_read(5'd30, 5'd30, v);
    checks++;
    if (v !== 1'b1) begin fails++; $display("[TB] FAIL read_30_30: got %b, required 1", v); end
    rd_x = 5'd0;
    rd_y = 5'd0;
    tick();
    checks++;
    if (rd_data !== 1'b1) begin fails++; $display("[TB] FAIL read_hold: got %b, required 1", rd_data); end
  endtask

  task automatic test_eat();
    logic acked, hit, v;
    int   lat;
    do_eat(5'd3, 5'd4, acked, hit, lat);
    checks++;
    if (!acked || lat != 3) begin
      fails++;
      $display("[TB] FAIL eat_latency: acked=%b after %0d cycles, required ack after 3", acked, lat);
    end
    checks++;
    if (hit !== 1'b1) begin fails++; $display("[TB] FAIL eat_hit: got %b, required 1", hit); end
    checks++;
    if (pellets_left !== 10'd899) begin
      fails++;
      $display("[TB] FAIL eat_pellets: got %0d, required 899", pellets_left);
    end
    tick();
    checks++;
    if (eat_ack !== 1'b0) begin fails++; $display("[TB] FAIL ack_one_cycle: got %b, required 0", eat_ack); end
    do_read(5'd3, 5'd4, v);
    checks++;
    if (v !== 1'b0) begin fails++; $display("[TB] FAIL read_eaten_3_4: got %b, required 0", v); end
  endtask

  task automatic test_repeat_and_border();
    logic acked, hit;
    int   lat;
    do_eat(5'd3, 5'd4, acked, hit, lat);
    checks++;
    if (!acked || hit !== 1'b0) begin
      fails++;
      $display("[TB] FAIL repeat_eat: acked=%b hit=%b, required acked=1 hit=0", acked, hit);
    end
    checks++;
    if (pellets_left !== 10'd899) begin
      fails++;
      $display("[TB] FAIL repeat_pellets: got %0d, required 899", pellets_left);
    end
    tick();
    do_eat(5'd0, 5'd7, acked, hit, lat);
    checks++;
    if (!acked || hit !== 1'b0 || lat != 3) begin
      fails++;
      $display("[TB] FAIL border_eat: acked=%b hit=%b lat=%0d, required 1/0/3", acked, hit, lat);
    end
    checks++;
    if (pellets_left !== 10'd899) begin
      fails++;
      $display("[TB] FAIL border_pellets: got %0d, required 899", pellets_left);
    end
    tick();
  endtask

  task automatic test_render_stall();
    logic acked, expv;
    int   lat, acks;
    acks    = 0;
    eat_req = 1'b1;
    eat_x   = 5'd5;
    eat_y   = 5'd5;
    rd_en   = 1'b1;
    rd_y    = 5'd4;
    for (int i = 1; i <= 20; i++) begin
      rd_x = 5'(i);
      tick();
      expv = (i != 3);
      checks++;
      if (rd_data !== expv) begin
        fails++;
        $display("[TB] FAIL stall_read_x%0d: got %b, required %b", i, rd_data, expv);
      end
      if (eat_ack !== 1'b0) acks++;
    end
    checks++;
    if (acks != 0) begin fails++; $display("[TB] FAIL stall_no_ack: %0d acks, required 0", acks); end
    rd_en = 1'b0;
    acked = 1'b0;
    lat   = 0;
    for (int i = 1; (i <= 3) && !acked; i++) begin
      tick();
      if (eat_ack === 1'b1) begin
        acked = 1'b1;
        lat   = i;
        checks++;
        if (eat_hit !== 1'b1) begin fails++; $display("[TB] FAIL stall_hit: got %b, required 1", eat_hit); end
        checks++;
        if (pellets_left !== 10'd898) begin
          fails++;
          $display("[TB] FAIL stall_pellets: got %0d, required 898", pellets_left);
        end
      end
    end
    eat_req = 1'b0;
    checks++;
    if (!acked) begin fails++; $display("[TB] FAIL stall_ack_after_release: none within 3 cycles (lat %0d)", lat); end
    tick();
  endtask

  task automatic test_level_start_abort();
    logic v;
    int   acks;
    acks = 0;
    do_read(5'd6, 5'd6, v);
    eat_req = 1'b1;
    eat_x   = 5'd6;
    eat_y   = 5'd6;
    tick();
    if (eat_ack !== 1'b0) acks++;
    tick();
    if (eat_ack !== 1'b0) acks++;
    level_start = 1'b1;
    eat_req     = 1'b0;
    tick();
    level_start = 1'b0;
    if (eat_ack !== 1'b0) acks++;
    checks++;
    if (acks != 0) begin fails++; $display("[TB] FAIL abort_no_ack: %0d acks, required 0", acks); end
    checks++;
    if (busy !== 1'b1 || rd_data !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_enter_init: busy=%b rd_data=%b, required 1/0", busy, rd_data);
    end
    test_init_sweep("restart");
    do_read(5'd3, 5'd4, v);
    checks++;
    if (v !== 1'b1) begin fails++; $display("[TB] FAIL refilled_3_4: got %b, required 1", v); end
    do_read(5'd6, 5'd6, v);
    checks++;
    if (v !== 1'b1) begin fails++; $display("[TB] FAIL refilled_6_6: got %b, required 1", v); end
  endtask

  task automatic test_clear_all();
    logic acked, hit, v;
    int   lat, bad;
    bad = 0;
    for (int y = 1; y <= 30; y++) begin
      for (int x = 1; x <= 30; x++) begin
        do_eat(5'(x), 5'(y), acked, hit, lat);
        if (!acked || hit !== 1'b1 || lat != 3) bad++;
        if (!(x == 30 && y == 30)) begin
          if (level_clear !== 1'b0) bad++;
          tick();
        end
      end
    end
    checks++;
    if (bad != 0) begin fails++; $display("[TB] FAIL clear_all_eats: %0d bad eats, required 0", bad); end
    checks++;
    if (pellets_left !== 10'd0 || level_clear !== 1'b0) begin
      fails++;
      $display("[TB] FAIL final_ack_cycle: pellets=%0d clear=%b, required 0/0", pellets_left, level_clear);
    end
    tick();
    checks++;
    if (level_clear !== 1'b1) begin fails++; $display("[TB] FAIL level_clear: got %b, required 1", level_clear); end
    do_eat(5'd1, 5'd1, acked, hit, lat);
    checks++;
    if (!acked || hit !== 1'b0 || pellets_left !== 10'd0) begin
      fails++;
      $display("[TB] FAIL empty_eat: acked=%b hit=%b pellets=%0d, required 1/0/0", acked, hit, pellets_left);
    end
    tick();
    do_read(5'd15, 5'd15, v);
    checks++;
    if (v !== 1'b0) begin fails++; $display("[TB] FAIL cleared_15_15: got %b, required 0", v); end
  endtask

  task automatic test_reset_mid_init();
    logic v;
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    checks++;
    if (level_clear !== 1'b0) begin fails++; $display("[TB] FAIL clear_in_init: got %b, required 0", level_clear); end
    test_init_sweep("refill");
    do_read(5'd1, 5'd1, v);
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    repeat (50) tick();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pellets_left !== 10'd0) begin
      fails++;
      $display("[TB] FAIL async_reset_pellets: got %0d, required 0", pellets_left);
    end
    checks++;
    if ({busy, rd_data, eat_ack, eat_hit, level_clear} !== 5'b10000) begin
      fails++;
      $display("[TB] FAIL async_reset_flags: got %b, required 10000",
               {busy, rd_data, eat_ack, eat_hit, level_clear});
    end
    tick();
    reset_n = 1'b1;
    test_init_sweep("post_reset");
    do_read(5'd3, 5'd4, v);
    checks++;
    if (v !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_3_4: got %b, required 1", v); end
  endtask

  initial begin
    test_reset();
    test_reads();
    test_eat();
    test_repeat_and_border();
    test_render_stall();
    test_level_start_abort();
    test_clear_all();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
